fp_cpu_issuer: RTL

FP_CPU_ISSUER -- requirements
Module: fp_cpu_issuer

---
 rtl/fp_cpu_issuer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fp_cpu_issuer.sv
// Command queue and issue sequencer between a host and a multi-cycle FP unit.
// Keeps at most one operation outstanding and returns one response per command.
module fp_cpu_issuer #(
   parameter int DEPTH   = 4,
   parameter int NUM_OPS = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [31:0]                  cmd_op1,
   input  logic [31:0]                  cmd_op2,
   input  logic [2:0]                   cmd_sel,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [31:0]                  rsp_result,
   output logic [2:0]                   rsp_sel,
   output logic                         rsp_err,
   output logic [31:0]                  fp_op1,
   output logic [31:0]                  fp_op2,
   output logic [2:0]                   fp_op_sel,
   output logic                         fp_op_strobe,
   output logic                         fp_cpu_pop,
   input  logic                         fp_cpu_hold,
   input  logic [31:0]                  fp_result,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {StIdle, StIssue, StGap, StWait, StCapt, StResp} state_e;

   state_e state_q, state_d;

   logic [31:0]   mem_op1 [DEPTH];
   logic [31:0]   mem_op2 [DEPTH];
   logic [2:0]    mem_sel [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop, fifo_empty, head_legal;

   logic [31:0] fp_op1_q, fp_op1_d, fp_op2_q, fp_op2_d, rsp_result_q, rsp_result_d;
   logic [2:0]  fp_op_sel_q, fp_op_sel_d, rsp_sel_q, rsp_sel_d;
   logic        rsp_err_q, rsp_err_d;

   assign cmd_ready  = (count_q < CW'(DEPTH));
   assign fifo_empty = (count_q == '0);
   assign head_legal = (32'(mem_sel[rd_ptr_q]) < 32'(NUM_OPS));
   assign push       = cmd_valid && cmd_ready;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_op1[wr_ptr_q] <= cmd_op1;
         mem_op2[wr_ptr_q] <= cmd_op2;
         mem_sel[wr_ptr_q] <= cmd_sel;
      end
   end

   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      fp_op_strobe = 1'b0;
      fp_cpu_pop   = 1'b0;
      fp_op1_d     = fp_op1_q;
      fp_op2_d     = fp_op2_q;
      fp_op_sel_d  = fp_op_sel_q;
      rsp_sel_d    = rsp_sel_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      unique case (state_q)
         StIdle: begin
            // Illegal codes bypass the FP unit, so hold does not gate them.
            if (!fifo_empty && (!head_legal || !fp_cpu_hold)) begin
               pop         = 1'b1;
               fp_op1_d    = mem_op1[rd_ptr_q];
               fp_op2_d    = mem_op2[rd_ptr_q];
               fp_op_sel_d = mem_sel[rd_ptr_q];
               rsp_sel_d   = mem_sel[rd_ptr_q];
               if (head_legal) begin
                  state_d = StIssue;
               end else begin
                  state_d      = StResp;
                  rsp_result_d = '0;
                  rsp_err_d    = 1'b1;
               end
            end
         end
         StIssue: begin
            fp_op_strobe = 1'b1;
            state_d      = StGap;
         end
         // The unit needs a cycle to raise hold after the strobe.
         StGap:  state_d = StWait;
         StWait: if (!fp_cpu_hold) state_d = StCapt;
         StCapt: begin
            fp_cpu_pop   = 1'b1;
            rsp_result_d = fp_result;
            rsp_err_d    = 1'b0;
            state_d      = StResp;
         end
         StResp: if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         fp_op1_q     <= '0;
         fp_op2_q     <= '0;
         fp_op_sel_q  <= '0;
         rsp_sel_q    <= '0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         fp_op1_q     <= fp_op1_d;
         fp_op2_q     <= fp_op2_d;
         fp_op_sel_q  <= fp_op_sel_d;
         rsp_sel_q    <= rsp_sel_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign rsp_valid  = (state_q == StResp);
   assign rsp_result = rsp_result_q;
   assign rsp_sel    = rsp_sel_q;
   assign rsp_err    = rsp_err_q;
   assign fp_op1     = fp_op1_q;
   assign fp_op2     = fp_op2_q;
   assign fp_op_sel  = fp_op_sel_q;
   assign busy       = (state_q != StIdle) || !fifo_empty;
   assign fifo_count = count_q;

endmodule
